// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// master: word source / serial sink side; slave: the transmitter itself.
interface piso_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output load_valid,
        input  load_ready,
        input  so,
        input  so_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready,
        output so,
        output so_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless streaming.
// Ports: clk, rst (async active-low), bus (piso_tx_if.slave):
//   din/load_valid/load_ready load handshake; so/so_valid serial stream;
//   busy while a frame is in progress; done on the final bit of each frame.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             last_bit;
    logic             final_cyc;
    logic             accept;
    logic             head;
    logic [WIDTH-1:0] shifted;

    // Last data bit of the frame is on so this cycle.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    // Final bit of the whole frame: parity bit if present, else last data bit.
`ifdef PISO_PARITY_EN
    assign final_cyc = (state_q == PAR);
`else
    assign final_cyc = last_bit;
`endif

    // Ready in the final cycle too, so the next word follows with no gap.
    assign bus.load_ready = (state_q == IDLE) || final_cyc;
    assign accept         = bus.load_valid && bus.load_ready;

    assign head    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                sreg_d = shifted;
                if (!last_bit) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A new word overrides the shift of the outgoing one.
        if (accept) begin
            sreg_d = bus.din;
            cnt_d  = '0;
`ifdef PISO_PARITY_EN
            par_d  = ^bus.din;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Serial output is taken only from registered state; din never reaches so.
    always_comb begin
        bus.so = 1'b0;
        unique case (state_q)
            IDLE:    bus.so = 1'b0;
            SHIFT:   bus.so = head;
`ifdef PISO_PARITY_EN
            PAR:     bus.so = par_q;
`endif
            default: bus.so = 1'b0;
        endcase
    end

    assign bus.so_valid = (state_q != IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = final_cyc;

`ifndef SYNTHESIS
    a_done_ready : assert property (
        @(posedge clk) disable iff (!rst) bus.done |-> bus.load_ready);
    a_idle_quiet : assert property (
        @(posedge clk) disable iff (!rst) !bus.busy |-> !bus.so);
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Random + directed bench for piso_tx, MSB-first and LSB-first instances.
// Reference model: per-instance queue of expected serial bits.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic       lv;
    logic [7:0] din_r;

    int n_chk;
    int n_fail;

    bit qm[$];
    bit ql[$];

    piso_tx_if #(.WIDTH(8)) bm ();
    piso_tx_if #(.WIDTH(8)) bl ();

    assign bm.din        = din_r;
    assign bm.load_valid = lv;
    assign bl.din        = din_r;
    assign bl.load_valid = lv;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_m_so"},    32'(bm.so),         0);
        chk({tag, "_m_sov"},   32'(bm.so_valid),   0);
        chk({tag, "_m_busy"},  32'(bm.busy),       0);
        chk({tag, "_m_done"},  32'(bm.done),       0);
        chk({tag, "_m_ready"}, 32'(bm.load_ready), 1);
        chk({tag, "_l_so"},    32'(bl.so),         0);
        chk({tag, "_l_sov"},   32'(bl.so_valid),   0);
        chk({tag, "_l_busy"},  32'(bl.busy),       0);
        chk({tag, "_l_done"},  32'(bl.done),       0);
        chk({tag, "_l_ready"}, 32'(bl.load_ready), 1);
    endtask

    // Expected outputs follow directly from what is still queued:
    // head bit on so, last queued bit is the final bit of the frame.
    task automatic cmp_all();
        bit em;
        bit el;
        em = (qm.size() > 0) ? qm[0] : 1'b0;
        el = (ql.size() > 0) ? ql[0] : 1'b0;
        chk("m_so",    32'(bm.so),         32'(em));
        chk("m_sov",   32'(bm.so_valid),   32'(qm.size() > 0));
        chk("m_busy",  32'(bm.busy),       32'(qm.size() > 0));
        chk("m_done",  32'(bm.done),       32'(qm.size() == 1));
        chk("m_ready", 32'(bm.load_ready), 32'(qm.size() <= 1));
        chk("l_so",    32'(bl.so),         32'(el));
        chk("l_sov",   32'(bl.so_valid),   32'(ql.size() > 0));
        chk("l_busy",  32'(bl.busy),       32'(ql.size() > 0));
        chk("l_done",  32'(bl.done),       32'(ql.size() == 1));
        chk("l_ready", 32'(bl.load_ready), 32'(ql.size() <= 1));
    endtask

    // One clock: drive at negedge, check, model the edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        bit acc;
        lv    = v;
        din_r = d;
        #1;
        cmp_all();
        acc = v && (qm.size() <= 1);
        @(posedge clk);
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                qm.push_back(d[7-i]);
                ql.push_back(d[i]);
            end
`ifdef PISO_PARITY_EN
            qm.push_back(^d);
            ql.push_back(^d);
`endif
        end
        @(negedge clk);
    endtask

    // Hold valid with d until the model says it is accepted.
    task automatic send(input logic [7:0] d);
        bit ok;
        bit r;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            r = (qm.size() <= 1);
            cyc(1'b1, d);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", 32'(ok), 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        lv     = 1'b1;
        din_r  = 8'hA5;

        // Reset held with valid asserted: nothing may start.
        @(negedge clk);
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        #1;
        chk_reset("rst_hold2");
        lv  = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single word, both bit orders.
        send(8'hA5);
        idle(11);

        // Single set bit: LSB-first shows it first, MSB-first last.
        send(8'h01);
        idle(11);

        // Back-to-back streaming with valid held high.
        send(8'hFF);
        send(8'h00);
        idle(11);

        // Pulse during a frame while not ready must be ignored.
        send(8'h81);
        idle(2);
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'h3C);
        idle(12);

`ifdef PISO_PARITY_EN
        send(8'h07);
        idle(11);
`endif

        // Reset mid-frame: outputs clear before any clock edge.
        send(8'hC3);
        idle(3);
        lv = 1'b1;
        din_r = 8'h99;
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        qm.delete();
        ql.delete();
        @(negedge clk);
        #1;
        chk_reset("rst_mid_hold");
        lv  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        send(8'h5A);
        idle(11);

        // Random traffic; din changes freely while not ready.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
